login_sequencer: RTL and testbench
==================================

# login_sequencer

Front-end sequencer for the access-control datapath. It collects a 16-bit user ID and then a 16-bit password from the toggle switches on shaped push-button strobes, and presents each to the access-control block as a tagged one-cycle load. It samples the grant after a fixed check latency, counts failed attempts and enforces a timed lockout. It sits between the button decoder / process control and access control, and drives the login status used by the LED/LCD logic.

## Interface
Parameters:
- MAX_ATTEMPTS, 3: consecutive failed checks that trigger lockout (≥1)
- CHECK_LATENCY, 2: cycles from password load to grant sample (≥1)
- LOCKOUT_CYCLES, 1000: lockout duration in cycles (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- sw_data  in  16  switch value (ToggleSwitch[15:0])
- enter  in  1  shaped one-cycle pulse: submit current sw_data
- logout  in  1  shaped one-cycle pulse: abort entry or log out
- access_grant  in  1  grant level from access control
- data_out  out  16  registered word to access control
- data_tag  out  1  0 = user ID, 1 = password (drives _Data_In[16])
- data_load  out  1  one-cycle load strobe
- logged_in  out  1  high while in GRANTED
- locked  out  1  high while in LOCKOUT
- userid  out  16  ID of the logged-in user, 0 otherwise
- fail_count  out  $clog2(MAX_ATTEMPTS+1)  consecutive failures
- state_code  out  3  current state encoding, for LCD/LED

## Operation
- States (package enum): IDLE=0, WAIT_PW=1, CHECK=2, GRANTED=3, LOCKOUT=4.
- IDLE + enter:
  - data_out←sw_data, data_tag←0, data_load pulse.
  - The ID is latched internally.
  - Next state is WAIT_PW.
- WAIT_PW + enter:
  - data_out←sw_data, data_tag←1, data_load pulse.
  - Timer←CHECK_LATENCY.
  - Next state is CHECK.
- WAIT_PW + logout: go to IDLE. No load is issued and fail_count is unchanged.
- CHECK: the timer decrements each cycle. In the cycle the timer reads 0, access_grant is sampled:
  - If 1: go to GRANTED; userid←latched ID; fail_count←0.
  - If 0 and fail_count+1 == MAX_ATTEMPTS: go to LOCKOUT; timer←LOCKOUT_CYCLES; fail_count←MAX_ATTEMPTS.
  - If 0 otherwise: fail_count++ and go to IDLE.
- GRANTED + logout: go to IDLE and set userid←0.
- LOCKOUT: the timer decrements. At 0, go to IDLE and set fail_count←0.
- enter is ignored in CHECK, GRANTED and LOCKOUT. logout is ignored in IDLE, CHECK and LOCKOUT.
- If enter and logout arrive in the same cycle, logout wins; enter is dropped.
- data_out holds its last value between loads. data_tag holds its value.
- The latched ID and data_out are never cleared except by reset.

## Timing
- Reset (rst=0, asynchronous) sets:
  - state IDLE
  - data_out 0, data_tag 0, data_load 0
  - logged_in 0, locked 0, userid 0
  - fail_count 0, state_code 0
  - timer 0
  
  Reset mid-operation (including during LOCKOUT) aborts immediately, with no load pulse.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Enter sampled at edge N causes data_load=1 in cycle N+1, with data_out/data_tag valid in the same cycle.
- Password load at cycle P causes the grant to be sampled at cycle P+CHECK_LATENCY. logged_in or the IDLE return is visible at P+CHECK_LATENCY+1.
- Lockout entry at cycle L makes locked=1 from L for LOCKOUT_CYCLES+1 cycles, then IDLE.
- data_load is never high for two consecutive cycles.
- state_code and logged_in/locked change in the same cycle as the state.

## Structure
- Shared package bits_please_pkg holds:
  - the state enum
  - TAG_USERID=1'b0 and TAG_PASSWORD=1'b1
  - default parameter constants
- Sub-module cycle_timer: a loadable down-counter with a zero flag, sized $clog2(max(CHECK_LATENCY, LOCKOUT_CYCLES)+1). It is shared by CHECK and LOCKOUT.
- The FSM and output registers live in login_sequencer.

## Test plan
- Successful login: enter with sw=16'h1234, then enter with sw=16'hBEEF; access_grant=1 at the sample cycle.
  - Required: data_load pulses with tag 0/16'h1234, then tag 1/16'hBEEF.
  - Required: logged_in=1 and userid=16'h1234 at P+3; fail_count=0.
- Three failures with grant held at 0:
  - Required: fail_count goes 1 then 2 with an IDLE return each time.
  - Required: the 3rd failure gives locked=1 for 1001 cycles, then IDLE with fail_count=0.
  - Required: enter pulses during lockout produce no data_load.
- Abort and logout:
  - logout in WAIT_PW goes to IDLE, with no password load and fail_count unchanged.
  - logout in GRANTED gives logged_in=0 and userid=0 on the next cycle.
- Simultaneous enter+logout in WAIT_PW goes to IDLE with no data_load. Simultaneous enter+logout in IDLE leaves the block in IDLE with no load.
- Async reset: assert rst=0 mid-CHECK and mid-LOCKOUT, off-edge.
  - Required: all outputs 0 immediately.
  - Required: after release, the next enter gives a tag-0 load.
- Grant glitch: access_grant=1 only outside the sample cycle counts as a failure, fail_count=1.

Source files
------------

// File: rtl/bits_please_pkg.sv
// Shared definitions for the login front-end: state encoding, load tags and
// default timing constants.
package bits_please_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_PW = 3'd1,
    CHECK   = 3'd2,
    GRANTED = 3'd3,
    LOCKOUT = 3'd4
  } login_state_t;

  localparam logic TAG_USERID   = 1'b0;
  localparam logic TAG_PASSWORD = 1'b1;

  localparam int DEF_MAX_ATTEMPTS   = 3;
  localparam int DEF_CHECK_LATENCY  = 2;
  localparam int DEF_LOCKOUT_CYCLES = 1000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag; saturates at zero so an idle
// decrement request is harmless.
module cycle_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/login_sequencer.sv
// Collects user ID and password from the switches, issues tagged loads to
// access control, samples the grant and enforces a timed lockout.
module login_sequencer
  import bits_please_pkg::*;
#(
  parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
  parameter int CHECK_LATENCY  = DEF_CHECK_LATENCY,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [15:0]                       sw_data,
  input  logic                              enter,
  input  logic                              logout,
  input  logic                              access_grant,
  output logic [15:0]                       data_out,
  output logic                              data_tag,
  output logic                              data_load,
  output logic                              logged_in,
  output logic                              locked,
  output logic [15:0]                       userid,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] fail_count,
  output logic [2:0]                        state_code
);

  localparam int TIMER_W = $clog2(max_int(CHECK_LATENCY, LOCKOUT_CYCLES) + 1);
  localparam int FAIL_W  = $clog2(MAX_ATTEMPTS + 1);

  login_state_t       state_reg;
  logic [15:0]        id_reg;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_load_value;
  logic               timer_dec;
  logic               timer_zero;
  logic               last_attempt;
  logic               pw_accept;
  logic               lockout_entry;

  assign last_attempt = (int'(fail_count) + 1 == MAX_ATTEMPTS);

  // A password enter right behind the ID load is dropped so data_load can
  // never be high on two consecutive cycles.
  assign pw_accept     = (state_reg == WAIT_PW) && enter && !logout && !data_load;
  assign lockout_entry = (state_reg == CHECK) && timer_zero && !access_grant && last_attempt;

  always_comb begin
    timer_load       = 1'b0;
    timer_load_value = '0;
    if (pw_accept) begin
      timer_load       = 1'b1;
      timer_load_value = TIMER_W'(CHECK_LATENCY);
    end else if (lockout_entry) begin
      timer_load       = 1'b1;
      timer_load_value = TIMER_W'(LOCKOUT_CYCLES);
    end
  end

  assign timer_dec = (state_reg == CHECK) || (state_reg == LOCKOUT);

  cycle_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_load_value),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      id_reg     <= '0;
      data_out   <= '0;
      data_tag   <= TAG_USERID;
      data_load  <= 1'b0;
      logged_in  <= 1'b0;
      locked     <= 1'b0;
      userid     <= '0;
      fail_count <= '0;
    end else begin
      data_load <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (enter && !logout) begin
            data_out  <= sw_data;
            data_tag  <= TAG_USERID;
            data_load <= 1'b1;
            id_reg    <= sw_data;
            state_reg <= WAIT_PW;
          end
        end
        WAIT_PW: begin
          if (logout) begin
            state_reg <= IDLE;
          end else if (pw_accept) begin
            data_out  <= sw_data;
            data_tag  <= TAG_PASSWORD;
            data_load <= 1'b1;
            state_reg <= CHECK;
          end
        end
        CHECK: begin
          if (timer_zero) begin
            if (access_grant) begin
              state_reg  <= GRANTED;
              logged_in  <= 1'b1;
              userid     <= id_reg;
              fail_count <= '0;
            end else if (last_attempt) begin
              state_reg  <= LOCKOUT;
              locked     <= 1'b1;
              fail_count <= FAIL_W'(MAX_ATTEMPTS);
            end else begin
              state_reg  <= IDLE;
              fail_count <= fail_count + FAIL_W'(1);
            end
          end
        end
        GRANTED: begin
          if (logout) begin
            state_reg <= IDLE;
            logged_in <= 1'b0;
            userid    <= '0;
          end
        end
        LOCKOUT: begin
          if (timer_zero) begin
            state_reg  <= IDLE;
            locked     <= 1'b0;
            fail_count <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          logged_in <= 1'b0;
          locked    <= 1'b0;
        end
      endcase
    end
  end

  assign state_code = state_reg;

endmodule

// File: tb/tb_login_sequencer.sv
// Directed bench for login_sequencer: expected loads are queued by the
// stimulus and matched by a monitor; status outputs are checked inline.
module tb_login_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sw_data = '0;
  logic        enter = 1'b0;
  logic        logout = 1'b0;
  logic        access_grant = 1'b0;
  logic [15:0] data_out;
  logic        data_tag;
  logic        data_load;
  logic        logged_in;
  logic        locked;
  logic [15:0] userid;
  logic [1:0]  fail_count;
  logic [2:0]  state_code;

  int total = 0;
  int bad = 0;
  logic [16:0] exp_q[$];
  logic prev_load = 1'b0;

  login_sequencer #(
    .MAX_ATTEMPTS(3),
    .CHECK_LATENCY(2),
    .LOCKOUT_CYCLES(1000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_data      (sw_data),
    .enter        (enter),
    .logout       (logout),
    .access_grant (access_grant),
    .data_out     (data_out),
    .data_tag     (data_tag),
    .data_load    (data_load),
    .logged_in    (logged_in),
    .locked       (locked),
    .userid       (userid),
    .fail_count   (fail_count),
    .state_code   (state_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every load must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (data_load) begin
        total++;
        if (prev_load) begin
          bad++;
          $display("FAIL back_to_back_load: got 1 want 0");
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_load: got tag=%0d data=%h want none", data_tag, data_out);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          if ({data_tag, data_out} !== e) begin
            bad++;
            $display("FAIL load: got tag=%0d data=%h want tag=%0d data=%h",
                     data_tag, data_out, e[16], e[15:0]);
          end else begin
            $display("ok   load: tag=%0d data=%h", data_tag, data_out);
          end
        end
      end
      prev_load = data_load;
    end else begin
      prev_load = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_enter(input logic [15:0] d);
    sw_data = d;
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic pulse_logout();
    logout = 1'b1;
    tick();
    logout = 1'b0;
  endtask

  // ID then password with grant low; returns at P+3.
  task automatic failed_attempt(input logic [15:0] id, input logic [15:0] pw);
    access_grant = 1'b0;
    exp_q.push_back({1'b0, id});
    pulse_enter(id);
    tick();
    exp_q.push_back({1'b1, pw});
    pulse_enter(pw);
    tick();
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"}, 32'(data_out), 32'h0);
    check({tag, "_data_tag"}, 32'(data_tag), 32'h0);
    check({tag, "_data_load"}, 32'(data_load), 32'h0);
    check({tag, "_logged_in"}, 32'(logged_in), 32'h0);
    check({tag, "_locked"}, 32'(locked), 32'h0);
    check({tag, "_userid"}, 32'(userid), 32'h0);
    check({tag, "_fail_count"}, 32'(fail_count), 32'h0);
    check({tag, "_state_code"}, 32'(state_code), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check_all_zero("reset");
    #3 rst = 1'b1;
    tick();

    // Successful login
    exp_q.push_back({1'b0, 16'h1234});
    pulse_enter(16'h1234);
    check("id_state", 32'(state_code), 32'd1);
    tick();
    access_grant = 1'b1;
    exp_q.push_back({1'b1, 16'hBEEF});
    pulse_enter(16'hBEEF);
    check("pw_state", 32'(state_code), 32'd2);
    tick();
    tick();
    check("login_p2_logged_in", 32'(logged_in), 32'd0);
    tick();
    check("login_p3_logged_in", 32'(logged_in), 32'd1);
    check("login_userid", 32'(userid), 32'h1234);
    check("login_fail_count", 32'(fail_count), 32'd0);
    check("login_state", 32'(state_code), 32'd3);
    access_grant = 1'b0;

    // Logout from GRANTED
    pulse_logout();
    check("logout_logged_in", 32'(logged_in), 32'd0);
    check("logout_userid", 32'(userid), 32'h0);
    check("logout_state", 32'(state_code), 32'd0);

    // Grant high only outside the sample cycle
    exp_q.push_back({1'b0, 16'h0001});
    pulse_enter(16'h0001);
    tick();
    exp_q.push_back({1'b1, 16'h0002});
    pulse_enter(16'h0002);
    access_grant = 1'b1;
    tick();
    access_grant = 1'b0;
    tick();
    tick();
    access_grant = 1'b1;
    check("glitch_state", 32'(state_code), 32'd0);
    check("glitch_fail_count", 32'(fail_count), 32'd1);
    check("glitch_logged_in", 32'(logged_in), 32'd0);
    access_grant = 1'b0;

    // Logout in WAIT_PW
    exp_q.push_back({1'b0, 16'h00AA});
    pulse_enter(16'h00AA);
    tick();
    pulse_logout();
    check("abort_state", 32'(state_code), 32'd0);
    check("abort_fail_count", 32'(fail_count), 32'd1);

    // Simultaneous enter+logout in WAIT_PW, then in IDLE
    exp_q.push_back({1'b0, 16'h00BB});
    pulse_enter(16'h00BB);
    tick();
    sw_data = 16'hCCCC;
    enter = 1'b1;
    logout = 1'b1;
    tick();
    enter = 1'b0;
    logout = 1'b0;
    check("both_wait_state", 32'(state_code), 32'd0);
    enter = 1'b1;
    logout = 1'b1;
    tick();
    enter = 1'b0;
    logout = 1'b0;
    tick();
    check("both_idle_state", 32'(state_code), 32'd0);
    check("both_idle_load", 32'(data_load), 32'd0);

    // Two more failures: second reaches lockout
    failed_attempt(16'h0011, 16'h0022);
    check("fail2_count", 32'(fail_count), 32'd2);
    check("fail2_state", 32'(state_code), 32'd0);
    failed_attempt(16'h0033, 16'h0044);
    check("lock_entry_locked", 32'(locked), 32'd1);
    check("lock_entry_state", 32'(state_code), 32'd4);
    check("lock_entry_fail_count", 32'(fail_count), 32'd3);
    for (int i = 0; i < 1000; i++) begin
      if (i == 10 || i == 500 || i == 998) begin
        sw_data = 16'hDEAD;
        enter = 1'b1;
      end
      tick();
      enter = 1'b0;
    end
    check("lock_last_locked", 32'(locked), 32'd1);
    check("lock_last_state", 32'(state_code), 32'd4);
    tick();
    check("lock_exit_locked", 32'(locked), 32'd0);
    check("lock_exit_state", 32'(state_code), 32'd0);
    check("lock_exit_fail_count", 32'(fail_count), 32'd0);

    // Async reset mid-CHECK
    exp_q.push_back({1'b0, 16'h5555});
    pulse_enter(16'h5555);
    tick();
    exp_q.push_back({1'b1, 16'h6666});
    pulse_enter(16'h6666);
    tick();
    #2 rst = 1'b0;
    #1;
    check_all_zero("rst_check");
    #3 rst = 1'b1;
    tick();
    exp_q.push_back({1'b0, 16'h7777});
    pulse_enter(16'h7777);
    check("rst_check_resume_state", 32'(state_code), 32'd1);
    tick();
    pulse_logout();

    // Async reset mid-LOCKOUT
    failed_attempt(16'h0101, 16'h0202);
    failed_attempt(16'h0303, 16'h0404);
    failed_attempt(16'h0505, 16'h0606);
    check("lock2_locked", 32'(locked), 32'd1);
    for (int i = 0; i < 50; i++) tick();
    #2 rst = 1'b0;
    #1;
    check_all_zero("rst_lock");
    #3 rst = 1'b1;
    tick();
    exp_q.push_back({1'b0, 16'h8888});
    pulse_enter(16'h8888);
    check("rst_lock_resume_state", 32'(state_code), 32'd1);

    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
